sram_weight_loader: RTL and testbench

// Write-side companion of the CNN weight SRAM. Accepts a byte stream of packed

---
 rtl/sram_weight_loader.sv | 104 ++++++++++
 tb/tb_sram_weight_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_weight_loader.sv
// ============================================================================
// Module  : sram_weight_loader
// Purpose : Packs a host byte stream into 72-bit words and writes them into the CNN weight SRAM.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_weight_loader #(
  parameter int WORDS  = 545,
  parameter int BPW    = 9,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 72
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              write_en,
  output logic [ADDR_W-1:0] addr_w,
  output logic [DATA_W-1:0] data_w,
  output logic              sta,
  output logic              load_done,
  output logic [15:0]       checksum
);

  localparam int CNT_W  = $clog2(BPW);
  localparam int PACK_W = DATA_W - 8;
  localparam logic [CNT_W-1:0]  c_LAST_BYTE = CNT_W'(BPW - 1);
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PACK  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_byte_cnt;
  logic [PACK_W-1:0] r_pack;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_byte_cnt <= '0;
      r_pack     <= '0;
      byte_ready <= 1'b0;
      write_en   <= 1'b0;
      addr_w     <= '0;
      data_w     <= '0;
      sta        <= 1'b0;
      load_done  <= 1'b0;
      checksum   <= '0;
    end else begin
      load_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (load_start) begin
            r_state    <= S_PACK;
            r_byte_cnt <= '0;
            addr_w     <= '0;
            checksum   <= '0;
            sta        <= 1'b0;
            byte_ready <= 1'b1;
          end
        end
        S_PACK: begin
          if (byte_valid && byte_ready) begin
            checksum <= checksum + 16'(byte_data);
            // Bytes shift in from the top so byte 0 ends up in the low lane.
            if (r_byte_cnt == c_LAST_BYTE) begin
              data_w     <= {byte_data, r_pack};
              write_en   <= 1'b1;
              byte_ready <= 1'b0;
              r_byte_cnt <= '0;
              r_state    <= S_WRITE;
            end else begin
              r_pack     <= {byte_data, r_pack[PACK_W-1:8]};
              r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
          end
        end
        S_WRITE: begin
          write_en <= 1'b0;
          if (addr_w == c_LAST_ADDR) begin
            r_state   <= S_DONE;
            sta       <= 1'b1;
            load_done <= 1'b1;
          end else begin
            addr_w     <= addr_w + ADDR_W'(1);
            byte_ready <= 1'b1;
            r_state    <= S_PACK;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_weight_loader.sv
// ============================================================================
// Module  : tb_sram_weight_loader
// Purpose : Self-checking bench for sram_weight_loader against a word/checksum reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sram_weight_loader;

  localparam int WORDS = 545;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        write_en;
  logic [9:0]  addr_w;
  logic [71:0] data_w;
  logic        sta;
  logic        load_done;
  logic [15:0] checksum;

  sram_weight_loader #(.WORDS(WORDS), .BPW(9), .ADDR_W(10), .DATA_W(72)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .write_en   (write_en),
    .addr_w     (addr_w),
    .data_w     (data_w),
    .sta        (sta),
    .load_done  (load_done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit timed_out = 1'b0;
  int cyc = 0;

  logic [9:0]  wr_addr[$];
  logic [71:0] wr_data[$];
  int          wr_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [71:0] exp_words[$];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port monitor: records every SRAM write and load_done pulse.
  always @(negedge clk) begin
    if (write_en) begin
      wr_addr.push_back(addr_w);
      wr_data.push_back(data_w);
      wr_cyc.push_back(cyc);
      chk("write_with_sta", {71'd0, sta}, 72'd0);
    end
    if (load_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      byte_valid = 1'b0;
      load_start = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    byte_valid = 1'b0;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Presents one byte until the DUT takes it; gaps randomly drop byte_valid.
  task automatic feed_byte(input logic [7:0] b, input bit gaps);
    int waited = 0;
    if (timed_out) return;
    forever begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 3) == 0) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
      end else begin
        byte_valid = 1'b1;
        byte_data  = b;
        if (byte_ready) break;
      end
      waited++;
      if (waited > 100) begin
        timed_out = 1'b1;
        checks++;
        errors++;
        $error("FAIL feed_timeout observed=no_accept expected=accept_within_100");
        return;
      end
    end
  endtask

  task automatic feed_word(input logic [71:0] w, input bit gaps);
    for (int k = 0; k < 9; k++) feed_byte(w[8*k +: 8], gaps);
  endtask

  // Random image into exp_words; returns its expected checksum.
  task automatic gen_image(output logic [15:0] sum);
    int s = 0;
    exp_words.delete();
    for (int i = 0; i < WORDS; i++) begin
      logic [71:0] w;
      w = {$urandom, $urandom, $urandom};
      exp_words.push_back(w);
      for (int k = 0; k < 9; k++) s += int'(w[8*k +: 8]);
    end
    sum = 16'(s);
  endtask

  task automatic check_load(input string tag, input logic [15:0] exp_sum, input bit cadence);
    int n;
    int bad_gap = 0;
    chk({tag, "_nwrites"}, 72'(wr_addr.size()), 72'(WORDS));
    n = (wr_addr.size() < WORDS) ? wr_addr.size() : WORDS;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 72'(wr_addr[i]), 72'(i));
      chk($sformatf("%s_data%0d", tag, i), wr_data[i], exp_words[i]);
      if (cadence && i > 0 && (wr_cyc[i] - wr_cyc[i-1]) != 10) bad_gap++;
    end
    if (cadence) chk({tag, "_cadence_bad"}, 72'(bad_gap), 72'd0);
    chk({tag, "_sta"}, {71'd0, sta}, 72'd1);
    chk({tag, "_done_cnt"}, 72'(done_cnt), 72'd1);
    if (n > 0) chk({tag, "_done_after_last"}, 72'(done_cyc), 72'(wr_cyc[n-1] + 1));
    chk({tag, "_checksum"}, 72'(checksum), 72'(exp_sum));
    chk({tag, "_ready_done"}, {71'd0, byte_ready}, 72'd0);
  endtask

  initial begin
    logic [15:0] exp_sum;
    logic [71:0] w;
    rst        = 1'b1;
    load_start = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle with byte_valid asserted: nothing may happen before load_start.
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    repeat (20) @(negedge clk);
    chk("idle_ready", {71'd0, byte_ready}, 72'd0);
    chk("idle_wen", {71'd0, write_en}, 72'd0);
    chk("idle_sta", {71'd0, sta}, 72'd0);
    chk("idle_done", {71'd0, load_done}, 72'd0);
    chk("idle_addr", 72'(addr_w), 72'd0);
    chk("idle_data", data_w, 72'd0);
    chk("idle_checksum", 72'(checksum), 72'd0);
    chk("idle_nwrites", 72'(wr_addr.size()), 72'd0);
    byte_valid = 1'b0;

    // First word 0x01..0x09.
    pulse_start();
    chk("start_ready", {71'd0, byte_ready}, 72'd1);
    for (int k = 1; k <= 9; k++) feed_byte(8'(k), 1'b0);
    idle(3);
    chk("w0_nwrites", 72'(wr_addr.size()), 72'd1);
    if (wr_addr.size() > 0) begin
      chk("w0_addr", 72'(wr_addr[0]), 72'd0);
      chk("w0_data", wr_data[0], 72'h090807060504030201);
    end
    chk("w0_checksum", 72'(checksum), 72'h002D);
    chk("w0_sta", {71'd0, sta}, 72'd0);

    // load_start during PACK must be ignored.
    pulse_start();
    chk("midpack_addr", 72'(addr_w), 72'd1);
    chk("midpack_checksum", 72'(checksum), 72'h002D);
    chk("midpack_ready", {71'd0, byte_ready}, 72'd1);

    // Words 1 and 2, then 5 bytes of word 3, then reset.
    for (int i = 1; i <= 2; i++) begin
      w = {$urandom, $urandom, $urandom};
      feed_word(w, 1'b1);
    end
    w = {$urandom, $urandom, $urandom};
    for (int k = 0; k < 5; k++) feed_byte(w[8*k +: 8], 1'b1);
    idle(1);
    chk("pre_rst_nwrites", 72'(wr_addr.size()), 72'd3);
    if (wr_addr.size() == 3) chk("pre_rst_addr2", 72'(wr_addr[2]), 72'd2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {71'd0, byte_ready}, 72'd0);
    chk("rst_wen", {71'd0, write_en}, 72'd0);
    chk("rst_addr", 72'(addr_w), 72'd0);
    chk("rst_data", data_w, 72'd0);
    chk("rst_sta", {71'd0, sta}, 72'd0);
    chk("rst_checksum", 72'(checksum), 72'd0);
    clear_log();
    idle(3);
    chk("rst_no_partial", 72'(wr_addr.size()), 72'd0);

    // Full image with random valid gaps.
    gen_image(exp_sum);
    pulse_start();
    for (int i = 0; i < WORDS; i++) feed_word(exp_words[i], 1'b1);
    idle(4);
    check_load("gap", exp_sum, 1'b0);

    // DONE ignores bytes, then reload on load_start.
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    repeat (5) @(negedge clk);
    chk("done_no_write", 72'(wr_addr.size()), 72'(WORDS));
    chk("done_checksum_hold", 72'(checksum), 72'(exp_sum));
    chk("done_addr_hold", 72'(addr_w), 72'(WORDS - 1));
    clear_log();
    pulse_start();
    chk("reload_sta", {71'd0, sta}, 72'd0);
    chk("reload_checksum", 72'(checksum), 72'd0);
    chk("reload_addr", 72'(addr_w), 72'd0);
    chk("reload_ready", {71'd0, byte_ready}, 72'd1);

    // Back-to-back image: byte_valid stays high through WRITE cycles.
    gen_image(exp_sum);
    for (int i = 0; i < WORDS; i++) feed_word(exp_words[i], 1'b0);
    idle(4);
    check_load("b2b", exp_sum, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
